countdown_timer: RTL and testbench
==================================

// Module: countdown_timer
// PURPOSE
//  Parametrised MM:SS countdown timer for the DE-board top level.
//  The user loads seconds, then minutes, from SW. Start/stop is on a key. Four HEX digits show the time.
//  LEDR flash on expiry. Key inputs are synchronised and edge-detected inside the block.
//  Clock rate and flash rate are parameters, so the bench runs with a small CLK_HZ.
// PARAMETERS
//  CLK_HZ      50_000_000  CLOCK_50 cycles per 1 s countdown tick
//  FLASH_DIV   12_500_000  cycles per LEDR flash half-period (default gives 2 Hz blink)
//  DEBOUNCE    16          cycles a synchronised key must be stable before an edge is accepted
// PORTS
//  CLOCK_50    in   1   system clock
//  reset       in   1   async, active-low (KEY[0]); clears all state
//  settimer_n  in   1   KEY[1], active-low, asynchronous to clock
//  toggle_n    in   1   KEY[2], active-low, asynchronous to clock
//  SW          in   8   BCD load value: SW[7:4] = tens digit, SW[3:0] = ones digit
//  LEDR        out  10  status / flash
//  HEX0..HEX3  out  7   each; active-low segments {g..a}
//                       HEX0 = sec ones, HEX1 = sec tens, HEX2 = min ones, HEX3 = min tens
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state = SET_SEC; sec = min = 00; prescaler = 0; flash phase = 0
//   - LEDR = 0; all HEX show "0"
//  Key front end:
//   - 2-FF synchroniser, then a DEBOUNCE-cycle stability filter.
//   - A falling edge (press) gives a 1-cycle pulse: set_p or tog_p.
//   - Latency from the pin to the pulse is at most DEBOUNCE+3 cycles.
//   - Holding a key produces exactly one pulse.
//  SW load clamp:
//   - Any BCD digit above 9 becomes 9.
//   - Seconds tens above 5 becomes 5. Max load is 99:59.
//  States, encoded 3 bits:
//   SET_SEC=0  HEX1:0 live-mirror the clamped SW; HEX3:2 show min.
//              set_p: latch sec, go to SET_MIN.
//   SET_MIN=1  HEX3:2 live-mirror the clamped SW; HEX1:0 show sec.
//              set_p: latch min, save preset = {min,sec}, go to STOPPED.
//   STOPPED=2  tog_p: clear prescaler, go to RUNNING; if time is 00:00, go to FLASH instead.
//              set_p: go to SET_SEC, time retained.
//   RUNNING=3  Prescaler counts 0..CLK_HZ-1; on wrap it decrements MM:SS in BCD.
//              Borrow chain: sec ones 0->9 borrows sec tens; sec tens 0->5 borrows min.
//              On 00:01 -> 00:00 go to FLASH in the same cycle.
//              tog_p: go to STOPPED, prescaler held.
//              Decrement and tog_p in the same cycle: tog_p wins, no decrement.
//   FLASH=4    Flash phase toggles every FLASH_DIV cycles; LEDR = {10{phase}}; HEX show 00:00.
//              set_p: go to SET_SEC.
//  Key pulses are ignored in any state not listed above.
//  LEDR outside FLASH: {7'b0, state[2:0]}.
//  Outputs are registered. A HEX or LEDR change appears 1 cycle after the state or count update.
//  Asserting reset in any state, mid-count included, returns to the reset values immediately.
// CONFIGURATION
//  TIMER_AUTO_RELOAD_EN defined:
//   - In FLASH, tog_p reloads {min,sec} = preset, clears the prescaler and goes to RUNNING.
//   - A preset of 00:00 stays in FLASH.
//  TIMER_AUTO_RELOAD_EN undefined:
//   - The preset register is removed.
//   - tog_p in FLASH is ignored; only set_p or reset leaves FLASH.
// TESTING  (CLK_HZ=10, FLASH_DIV=3, DEBOUNCE=2)
//  reset low for 3 cycles -> state 0, LEDR=0, HEX0..3=7'b1000000.
//  SW=8'h7C in SET_SEC -> HEX1:0 show "59".
//   set_p -> SET_MIN; SW=8'h02, set_p -> STOPPED, LEDR=10'd2, display 02:59.
//  Load 01:00, tog_p -> after 10 cycles 00:59.
//   After 60 ticks total -> FLASH; LEDR alternates 3FF/000 every 3 cycles.
//  Load 00:05, start, tog_p on the exact wrap cycle of tick 2
//   -> STOPPED showing 00:04; next tog_p resumes, no lost or double tick.
//  Hold toggle_n low for 40 cycles in STOPPED -> exactly one RUNNING entry.
//   A 1-cycle glitch (< DEBOUNCE) -> no state change.
//  Drop reset mid-RUNNING at 00:03 -> immediate 00:00, SET_SEC.
//  AUTO_RELOAD_EN: in FLASH after preset 00:02, tog_p -> RUNNING at 00:02.
//   Macro undefined: the same stimulus stays in FLASH.

Source files
------------

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - MM:SS countdown timer with key front end, BCD load clamp and flashing expiry
//
// Purpose: the user loads seconds, then minutes, from SW. A key starts and stops the countdown,
// and LEDR flash once the time reaches 00:00.
// Optional feature macro: TIMER_AUTO_RELOAD_EN. When it is defined, toggle in FLASH reloads the preset.
//
// Ports:
//   CLOCK_50    in   1   system clock
//   reset       in   1   asynchronous active-low reset; its release is synchronised inside
//   settimer_n  in   1   set key, active-low, asynchronous to the clock
//   toggle_n    in   1   start/stop key, active-low, asynchronous to the clock
//   SW          in   8   BCD load value {tens, ones}
//   LEDR        out  10  state code, or the flash pattern while expired
//   HEX0..HEX3  out  7   active-low segments {g..a}: sec ones, sec tens, min ones, min tens
module countdown_timer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int FLASH_DIV = 12_500_000,
  parameter int DEBOUNCE  = 16
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       settimer_n,
  input  logic       toggle_n,
  input  logic [7:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);
  localparam logic [FW-1:0] FL_LAST = FW'(FLASH_DIV - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    SET_SEC = 3'd0,
    SET_MIN = 3'd1,
    STOPPED = 3'd2,
    RUNNING = 3'd3,
    FLASH   = 3'd4
  } state_t;

  // Assert asynchronously, release on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  // Key front end. Index 0 is the set key and index 1 is the toggle key.
  logic [1:0]         key_raw, key_s1, key_s2, key_f, key_p;
  logic [1:0][DW-1:0] db_cnt;
  logic               set_p, tog_p;

  assign key_raw = {toggle_n, settimer_n};

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
      key_f  <= 2'b11;
      key_p  <= 2'b00;
      db_cnt <= '0;
    end else begin
      key_s1 <= key_raw;
      key_s2 <= key_s1;
      for (int k = 0; k < 2; k++) begin
        key_p[k] <= 1'b0;
        // The filtered level follows only after DEBOUNCE consecutive disagreeing samples.
        if (key_s2[k] == key_f[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          db_cnt[k] <= '0;
          key_f[k]  <= key_s2[k];
          key_p[k]  <= ~key_s2[k];
        end else begin
          db_cnt[k] <= db_cnt[k] + DW'(1);
        end
      end
    end
  end

  assign set_p = key_p[0];
  assign tog_p = key_p[1];

  // Clamp the load value. Seconds tens saturates at 5, and every other digit saturates at 9.
  logic [3:0] sw_hi, sw_lo, ld_sec_t;
  assign sw_hi    = (SW[7:4] > 4'd9) ? 4'd9 : SW[7:4];
  assign sw_lo    = (SW[3:0] > 4'd9) ? 4'd9 : SW[3:0];
  assign ld_sec_t = (SW[7:4] > 4'd5) ? 4'd5 : SW[7:4];

  state_t         state;
  logic [15:0]    tm;          // {min tens, min ones, sec tens, sec ones}, BCD
  logic [PW-1:0]  presc;
  logic [FW-1:0]  flash_cnt;
  logic           phase;
`ifdef TIMER_AUTO_RELOAD_EN
  logic [15:0]    preset;
`endif

  // BCD decrement with the borrow chain sec ones -> sec tens (0->5) -> min ones -> min tens.
  logic [15:0] dec;
  always_comb begin
    dec = tm;
    if (tm[3:0] != 4'd0) begin
      dec[3:0] = tm[3:0] - 4'd1;
    end else begin
      dec[3:0] = 4'd9;
      if (tm[7:4] != 4'd0) begin
        dec[7:4] = tm[7:4] - 4'd1;
      end else begin
        dec[7:4] = 4'd5;
        if (tm[11:8] != 4'd0) begin
          dec[11:8] = tm[11:8] - 4'd1;
        end else begin
          dec[11:8]  = 4'd9;
          dec[15:12] = tm[15:12] - 4'd1;
        end
      end
    end
  end

  // Digits to display. The set states show the clamped SW value live in the field being loaded.
  logic [15:0] disp;
  always_comb begin
    case (state)
      SET_SEC: disp = {tm[15:8], ld_sec_t, sw_lo};
      SET_MIN: disp = {sw_hi, sw_lo, tm[7:0]};
      FLASH:   disp = 16'h0000;
      default: disp = tm;
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SET_SEC;
      tm        <= 16'h0000;
      presc     <= '0;
      flash_cnt <= '0;
      phase     <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      preset    <= 16'h0000;
`endif
      LEDR      <= 10'd0;
      HEX0      <= 7'b1000000;
      HEX1      <= 7'b1000000;
      HEX2      <= 7'b1000000;
      HEX3      <= 7'b1000000;
    end else begin
      // The outputs follow the current registers, so they lag a state or count change by one cycle.
      LEDR <= (state == FLASH) ? {10{phase}} : {7'b0, state};
      HEX0 <= seg7(disp[3:0]);
      HEX1 <= seg7(disp[7:4]);
      HEX2 <= seg7(disp[11:8]);
      HEX3 <= seg7(disp[15:12]);

      case (state)
        SET_SEC: begin
          if (set_p) begin
            tm[7:0] <= {ld_sec_t, sw_lo};
            state   <= SET_MIN;
          end
        end
        SET_MIN: begin
          if (set_p) begin
            tm[15:8] <= {sw_hi, sw_lo};
`ifdef TIMER_AUTO_RELOAD_EN
            preset   <= {sw_hi, sw_lo, tm[7:0]};
`endif
            state    <= STOPPED;
          end
        end
        STOPPED: begin
          if (tog_p) begin
            presc <= '0;
            if (tm == 16'h0000) begin
              state     <= FLASH;
              flash_cnt <= '0;
              phase     <= 1'b0;
            end else begin
              state <= RUNNING;
            end
          end else if (set_p) begin
            state <= SET_SEC;
          end
        end
        RUNNING: begin
          // A stop request beats a coincident tick, and the prescaler holds its value.
          if (tog_p) begin
            state <= STOPPED;
          end else if (presc == PS_LAST) begin
            presc <= '0;
            tm    <= dec;
            if (tm == 16'h0001) begin
              state     <= FLASH;
              flash_cnt <= '0;
              phase     <= 1'b0;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        FLASH: begin
          if (flash_cnt == FL_LAST) begin
            flash_cnt <= '0;
            phase     <= ~phase;
          end else begin
            flash_cnt <= flash_cnt + FW'(1);
          end
          if (set_p) begin
            state <= SET_SEC;
          end
`ifdef TIMER_AUTO_RELOAD_EN
          else if (tog_p && preset != 16'h0000) begin
            tm    <= preset;
            presc <= '0;
            state <= RUNNING;
          end
`endif
        end
        default: state <= SET_SEC;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed and randomized self-checking bench for countdown_timer
module tb_countdown_timer;

  localparam int CLK_HZ    = 10;
  localparam int FLASH_DIV = 3;
  localparam int DEBOUNCE  = 2;

  logic       CLOCK_50   = 1'b0;
  logic       reset      = 1'b0;
  logic       settimer_n = 1'b1;
  logic       toggle_n   = 1'b1;
  logic [7:0] SW         = 8'h00;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  countdown_timer #(.CLK_HZ(CLK_HZ), .FLASH_DIV(FLASH_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .settimer_n (settimer_n),
    .toggle_n   (toggle_n),
    .SW         (SW),
    .LEDR       (LEDR),
    .HEX0       (HEX0),
    .HEX1       (HEX1),
    .HEX2       (HEX2),
    .HEX3       (HEX3)
  );

  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic int clamp9(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  function automatic int sw_sec(input int v);
    int t;
    t = v / 16;
    if (t > 5) t = 5;
    return t * 10 + clamp9(v % 16);
  endfunction

  function automatic int sw_min(input int v);
    return clamp9(v / 16) * 10 + clamp9(v % 16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input int mm, input int ss);
    chk({tag, " hex0"}, {25'd0, HEX0}, {25'd0, seg_tab[ss % 10]});
    chk({tag, " hex1"}, {25'd0, HEX1}, {25'd0, seg_tab[ss / 10]});
    chk({tag, " hex2"}, {25'd0, HEX2}, {25'd0, seg_tab[mm % 10]});
    chk({tag, " hex3"}, {25'd0, HEX3}, {25'd0, seg_tab[mm / 10]});
  endtask

  task automatic chk_time(input string tag, input int t);
    chk_disp(tag, t / 60, t % 60);
  endtask

  task automatic chk_flashing(input string tag);
    chk(tag, {31'd0, (LEDR == 10'h3FF || LEDR == 10'h000)}, 32'd1);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge CLOCK_50);
  endtask

  task automatic drive_key(input int which, input logic level);
    if (which == 0) settimer_n = level;
    else            toggle_n   = level;
  endtask

  task automatic press(input int which);
    drive_key(which, 1'b0);
    step(10);
    drive_key(which, 1'b1);
    step(12);
  endtask

  // Press a key, then return the posedge at which LEDR first shows the target state and the latency from the pin.
  task automatic press_measure(input int which, input logic [9:0] target, output int entry, output int lat);
    int c0;
    bit seen;
    c0 = cyc;
    seen = 1'b0;
    drive_key(which, 1'b0);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLOCK_50);
      if (LEDR == target) seen = 1'b1;
    end
    drive_key(which, 1'b1);
    entry = cyc - 1;
    lat   = entry - c0;
    chk("state entry seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic load(input logic [7:0] sec_v, input logic [7:0] min_v);
    SW = sec_v;
    step(1);
    press(0);
    SW = min_v;
    step(1);
    press(0);
  endtask

  int s, lat, lat2, r, entries, v, vs, vm;
  logic [9:0] prev, fv;
  bit flipped;

  initial begin
    // Reset values while reset is held low.
    step(3);
    chk("reset ledr", {22'd0, LEDR}, 32'd0);
    chk_disp("reset", 0, 0);
    reset = 1'b1;
    step(4);
    chk("after reset state", {22'd0, LEDR}, 32'd0);

    // Clamped mirror in SET_SEC, then a load of 02:59.
    SW = 8'h7C;
    step(2);
    chk("mirror 59 hex1", {25'd0, HEX1}, {25'd0, seg_tab[5]});
    chk("mirror 59 hex0", {25'd0, HEX0}, {25'd0, seg_tab[9]});
    press(0);
    chk("set_min state", {22'd0, LEDR}, 32'd1);
    SW = 8'h02;
    step(2);
    chk_disp("set_min mirror", 2, 59);
    press(0);
    chk("stopped state", {22'd0, LEDR}, 32'd2);
    chk_disp("stopped 02:59", 2, 59);

    // Back to SET_SEC with minutes retained, then a random live mirror.
    press(0);
    chk("set_sec again", {22'd0, LEDR}, 32'd0);
    chk_disp("set_sec retain", 2, sw_sec(32'(SW)));
    for (int i = 0; i < 6; i++) begin
      v = $urandom_range(0, 255);
      SW = v[7:0];
      step(2);
      chk_disp("rand mirror", 2, sw_sec(v));
    end

    // Random full loads, starting with the saturating 99:59 case.
    for (int i = 0; i < 3; i++) begin
      vs = (i == 0) ? 255 : $urandom_range(0, 255);
      vm = (i == 0) ? 255 : $urandom_range(0, 255);
      load(vs[7:0], vm[7:0]);
      chk("rand load state", {22'd0, LEDR}, 32'd2);
      chk_disp("rand load", sw_min(vm), sw_sec(vs));
      press(0);
    end

    // Count down 01:00 to expiry.
    load(8'h00, 8'h01);
    chk_time("load 01:00", 60);
    press_measure(1, 10'd3, s, lat);
    chk("key latency bound", {31'd0, (lat <= DEBOUNCE + 3 && lat > 0)}, 32'd1);
    wait_cyc(s + CLK_HZ);
    chk_time("before tick1", 60);
    wait_cyc(s + CLK_HZ + 1);
    chk_time("tick1", 59);
    v = $urandom_range(2, 58);
    wait_cyc(s + v * CLK_HZ + 1);
    chk_time("rand tick", 60 - v);
    wait_cyc(s + 60 * CLK_HZ);
    chk_time("last second", 1);
    chk("running ledr", {22'd0, LEDR}, 32'd3);
    wait_cyc(s + 60 * CLK_HZ + 1);
    chk_time("expired", 0);
    chk_flashing("flash entry");

    // The flash pattern alternates every FLASH_DIV cycles.
    prev = LEDR;
    flipped = 1'b0;
    for (int i = 0; i < 10 && !flipped; i++) begin
      step(1);
      if (LEDR != prev) flipped = 1'b1;
    end
    chk("flash flip seen", {31'd0, flipped}, 32'd1);
    fv = LEDR;
    chk_flashing("flash level");
    for (int i = 1; i < 10; i++) begin
      step(1);
      chk("flash period", {22'd0, LEDR}, {22'd0, (((i / FLASH_DIV) % 2) != 0) ? ~fv : fv});
    end

    // Stop exactly on the wrap cycle of the second tick.
    press(0);
    chk("flash to set_sec", {22'd0, LEDR}, 32'd0);
    load(8'h05, 8'h00);
    chk_time("load 00:05", 5);
    press_measure(1, 10'd3, s, lat2);
    wait_cyc(s + CLK_HZ + 1);
    chk_time("wrap test tick1", 4);
    wait_cyc(s + 2 * CLK_HZ - lat2);
    toggle_n = 1'b0;
    wait_cyc(s + 2 * CLK_HZ + 2);
    chk("stop on wrap state", {22'd0, LEDR}, 32'd2);
    chk_time("stop on wrap time", 4);
    step(8);
    toggle_n = 1'b1;
    step(12);
    chk_time("held while stopped", 4);
    press_measure(1, 10'd3, r, lat2);
    wait_cyc(r + CLK_HZ);
    chk_time("resume no early tick", 4);
    wait_cyc(r + CLK_HZ + 1);
    chk_time("resume tick", 3);

    // Reset mid-count returns to the reset values at once.
    reset = 1'b0;
    #1;
    chk("async reset ledr", {22'd0, LEDR}, 32'd0);
    chk_time("async reset", 0);
    step(3);
    reset = 1'b1;
    step(4);
    chk("post reset state", {22'd0, LEDR}, 32'd0);
    chk_disp("post reset", 0, sw_sec(32'(SW)));

    // Holding toggle gives one start, and a short glitch is filtered.
    load(8'h30, 8'h00);
    chk_time("load 00:30", 30);
    toggle_n = 1'b0;
    entries = 0;
    prev = LEDR;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (LEDR == 10'd3 && prev != 10'd3) entries++;
      prev = LEDR;
    end
    toggle_n = 1'b1;
    chk("hold single start", 32'(entries), 32'd1);
    chk("hold running", {22'd0, LEDR}, 32'd3);
    step(12);
    press(1);
    chk("stopped again", {22'd0, LEDR}, 32'd2);
    toggle_n = 1'b0;
    step(1);
    toggle_n = 1'b1;
    step(15);
    chk("toggle glitch", {22'd0, LEDR}, 32'd2);
    settimer_n = 1'b0;
    step(1);
    settimer_n = 1'b1;
    step(15);
    chk("set glitch", {22'd0, LEDR}, 32'd2);

    // Toggle while expired, with and without auto reload.
    press(0);
    chk("to set_sec", {22'd0, LEDR}, 32'd0);
    load(8'h02, 8'h00);
    chk_time("load 00:02", 2);
    press_measure(1, 10'd3, s, lat2);
    wait_cyc(s + 2 * CLK_HZ + 1);
    chk_time("00:02 expired", 0);
    chk_flashing("00:02 flash");
`ifdef TIMER_AUTO_RELOAD_EN
    press_measure(1, 10'd3, s, lat2);
    chk_time("auto reload", 2);
    step(3 * CLK_HZ);
    chk_flashing("reload expired");
`else
    press(1);
    chk_flashing("toggle ignored in flash");
    chk_time("toggle ignored time", 0);
`endif
    press(0);
    chk("set leaves flash", {22'd0, LEDR}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
